// File: rtl/pulse_transmitter.sv
// pulse_transmitter: turns (high_ticks, low_ticks) symbols into a single-bit
// line. One tick lasts DIVISOR clocks. The prescaler restarts at 0 whenever a
// phase starts, so each symbol's timing does not depend on what came before.
module pulse_transmitter #(
  parameter int DIVISOR = 5,
  parameter int WIDTH   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_high_ticks,
  input  logic [WIDTH-1:0] i_low_ticks,
  output logic             o_pulse,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_done,
  output logic             o_busy
);

  localparam int PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIVISOR - 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] low_reg, low_next;
  logic             pulse_reg, pulse_next;
  logic             rise_reg, fall_reg;
  logic             zero_done_reg, zero_done_next;

  logic             presc_wrap;
  logic             phase_end;
  logic             final_clk;
  logic             transfer;

  // Phase/symbol boundary decode. A HIGH phase with no LOW phase behind it
  // is the last clock of its symbol, which is what allows seamless joins.
  always_comb begin
    presc_wrap = (presc_reg == PRESC_LAST);
    phase_end  = (state_reg != IDLE) && presc_wrap && (count_reg == WIDTH'(1));
    final_clk  = phase_end && ((state_reg == LOW) ||
                               ((state_reg == HIGH) && (low_reg == '0)));
    o_ready    = i_reset_n && ((state_reg == IDLE) || final_clk);
    transfer   = i_valid && o_ready;
    o_busy     = (state_reg != IDLE);
    // An empty symbol never leaves IDLE, so its done strobe comes from a flag.
    o_done     = final_clk || zero_done_reg;
    o_pulse    = pulse_reg;
    o_rise     = rise_reg;
    o_fall     = fall_reg;
  end

  // Next-state: run the current phase, then let an accepted symbol override.
  always_comb begin
    state_next     = state_reg;
    presc_next     = presc_reg;
    count_next     = count_reg;
    low_next       = low_reg;
    pulse_next     = pulse_reg;
    zero_done_next = 1'b0;

    if (final_clk) begin
      state_next = IDLE;
      presc_next = '0;
      count_next = '0;
      pulse_next = 1'b0;
    end else if (phase_end) begin
      // End of HIGH with a non-empty LOW phase to follow.
      state_next = LOW;
      presc_next = '0;
      count_next = low_reg;
      pulse_next = 1'b0;
    end else if (state_reg != IDLE) begin
      presc_next = presc_wrap ? '0 : presc_reg + 1'b1;
      if (presc_wrap) begin
        count_next = count_reg - 1'b1;
      end
    end

    if (transfer) begin
      presc_next = '0;
      low_next   = i_low_ticks;
      if (i_high_ticks != '0) begin
        state_next = HIGH;
        count_next = i_high_ticks;
        pulse_next = 1'b1;
      end else if (i_low_ticks != '0) begin
        state_next = LOW;
        count_next = i_low_ticks;
        pulse_next = 1'b0;
      end else begin
        state_next     = IDLE;
        count_next     = '0;
        pulse_next     = 1'b0;
        zero_done_next = 1'b1;
      end
    end
  end

  // State register; reset aborts any symbol and drops the line at once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= IDLE;
      presc_reg     <= '0;
      count_reg     <= '0;
      low_reg       <= '0;
      pulse_reg     <= 1'b0;
      rise_reg      <= 1'b0;
      fall_reg      <= 1'b0;
      zero_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      count_reg     <= count_next;
      low_reg       <= low_next;
      pulse_reg     <= pulse_next;
      rise_reg      <= pulse_next & ~pulse_reg;
      fall_reg      <= ~pulse_next & pulse_reg;
      zero_done_reg <= zero_done_next;
    end
  end

endmodule

// File: tb/tb_pulse_transmitter.sv
// Directed bench for pulse_transmitter. Each cycle checks the output vector
// {pulse, rise, fall, done, ready, busy} against hand-derived cycle windows.
module tb_pulse_transmitter;

  logic        clk;
  logic        rst_n;
  logic        valid, valid1;
  logic [15:0] hi, lo, hi1, lo1;
  logic        ready, pulse, rise, fall, done, busy;
  logic        ready1, pulse1, rise1, fall1, done1, busy1;

  int tests_run;
  int tests_failed;

  pulse_transmitter #(.DIVISOR(5), .WIDTH(16)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_high_ticks(hi), .i_low_ticks(lo), .o_pulse(pulse), .o_rise(rise),
    .o_fall(fall), .o_done(done), .o_busy(busy)
  );

  pulse_transmitter #(.DIVISOR(1), .WIDTH(16)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid1), .o_ready(ready1),
    .i_high_ticks(hi1), .i_low_ticks(lo1), .o_pulse(pulse1), .o_rise(rise1),
    .o_fall(fall1), .o_done(done1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [5:0] obs;
    rst_n = 1'b0; valid = 1'b0; hi = '0; lo = '0;
    valid1 = 1'b0; hi1 = '0; lo1 = '0;
    #2;
    obs = {pulse, rise, fall, done, ready, busy};
    tests_run++;
    if (obs !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_active got=%b exp=%b", obs, 6'b000000);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    obs = {pulse, rise, fall, done, ready, busy};
    tests_run++;
    if (obs !== 6'b000010) begin
      tests_failed++;
      $display("FAIL reset_release got=%b exp=%b", obs, 6'b000010);
    end
    $display("[TB] reset done");
  endtask

  // H=3, L=2; inputs scrambled after the transfer must be ignored.
  task automatic test_basic();
    logic [5:0] obs, exp;
    @(negedge clk);
    valid = 1'b1; hi = 16'd3; lo = 16'd2;
    #1;
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_ready_idle got=%b exp=1", ready);
    end
    for (int k = 1; k <= 27; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin valid = 1'b0; hi = 16'd9; lo = 16'd9; end
      exp = {k <= 15, k == 1, k == 16, k == 25, k >= 25, k <= 25};
      obs = {pulse, rise, fall, done, ready, busy};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL basic k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    $display("[TB] basic H=3 L=2 done");
  endtask

  // Second symbol offered (and its fields changed) while the first runs.
  task automatic test_back_to_back();
    logic [5:0] obs, exp;
    @(negedge clk);
    valid = 1'b1; hi = 16'd3; lo = 16'd2;
    for (int k = 1; k <= 37; k++) begin
      @(posedge clk); #1;
      if (k == 1)  begin hi = 16'd1; lo = 16'd1; end
      if (k == 26) begin valid = 1'b0; hi = 16'd7; lo = 16'd7; end
      exp = {(k <= 15) || (k >= 26 && k <= 30),
             k == 1 || k == 26,
             k == 16 || k == 31,
             k == 25 || k == 35,
             k == 25 || k >= 35,
             k <= 35};
      obs = {pulse, rise, fall, done, ready, busy};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL back_to_back k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    $display("[TB] back-to-back done");
  endtask

  task automatic test_zero_high();
    logic [5:0] obs, exp;
    @(negedge clk);
    valid = 1'b1; hi = 16'd0; lo = 16'd4;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (k == 1) valid = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, k == 20, k >= 20, k <= 20};
      obs = {pulse, rise, fall, done, ready, busy};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL zero_high k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    $display("[TB] H=0 L=4 done");
  endtask

  task automatic test_high_join();
    logic [5:0] obs, exp;
    @(negedge clk);
    valid = 1'b1; hi = 16'd2; lo = 16'd0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (k == 11) valid = 1'b0;
      exp = {k <= 20, k == 1, k == 21, k == 10 || k == 20,
             k == 10 || k >= 20, k <= 20};
      obs = {pulse, rise, fall, done, ready, busy};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL high_join k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    $display("[TB] H=2 L=0 join done");
  endtask

  task automatic test_zero_zero();
    logic [5:0] obs, exp;
    @(negedge clk);
    valid = 1'b1; hi = 16'd0; lo = 16'd0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) valid = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, k == 1, 1'b1, 1'b0};
      obs = {pulse, rise, fall, done, ready, busy};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL zero_zero k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    $display("[TB] H=0 L=0 done");
  endtask

  task automatic test_div1();
    logic [5:0] obs, exp;
    @(negedge clk);
    valid1 = 1'b1; hi1 = 16'd1; lo1 = 16'd1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) valid1 = 1'b0;
      exp = {k == 1, k == 1, k == 2, k == 2, k >= 2, k <= 2};
      obs = {pulse1, rise1, fall1, done1, ready1, busy1};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL div1 k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    $display("[TB] DIVISOR=1 done");
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs, exp;
    @(negedge clk);
    valid = 1'b1; hi = 16'd3; lo = 16'd2;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 1) valid = 1'b0;
    end
    tests_run++;
    if (pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_pre got=%b exp=1", pulse);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {pulse, rise, fall, done, ready, busy};
    tests_run++;
    if (obs !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_mid_async got=%b exp=%b", obs, 6'b000000);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      obs = {pulse, rise, fall, done, ready, busy};
      tests_run++;
      if (obs !== 6'b000000) begin
        tests_failed++;
        $display("FAIL reset_mid_hold k=%0d got=%b exp=%b", k, obs, 6'b000000);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    obs = {pulse, rise, fall, done, ready, busy};
    tests_run++;
    if (obs !== 6'b000010) begin
      tests_failed++;
      $display("FAIL reset_mid_release got=%b exp=%b", obs, 6'b000010);
    end
    @(negedge clk);
    valid = 1'b1; hi = 16'd1; lo = 16'd1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) valid = 1'b0;
      exp = {k <= 5, k == 1, k == 6, k == 10, k >= 10, k <= 10};
      obs = {pulse, rise, fall, done, ready, busy};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL reset_mid_fresh k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    $display("[TB] reset mid-symbol done");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_high();
    test_high_join();
    test_zero_zero();
    test_div1();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pulse_transmitter.md
Name: pulse_transmitter

Overview:
- Waveform generator: the transmit-side counterpart of the edge-timed pulse-width measurement path.
- Accepts one symbol per valid/ready handshake. A symbol is a high width and a low width, both in ticks.
- Drives a single-bit line. The line is high for high_ticks*DIVISOR clocks, then low for low_ticks*DIVISOR clocks.
- Tick timing matches the receive-side clock enable: DIVISOR clocks per tick, with the prescaler phase realigned at the start of every symbol.
- Used for loopback stimulus and for driving LED/line outputs.

Parameters:
- DIVISOR, 5: clocks per tick. Legal range ≥1; 1 means one tick per clock.
- WIDTH, 16: width of the tick-count fields. Maximum phase length is (2^WIDTH-1) ticks.

Ports:
- i_clk  input  1  clock
- i_reset_n  input  1  asynchronous active-low reset
- i_valid  input  1  symbol offered
- o_ready  output  1  block can accept a symbol this cycle
- i_high_ticks  input  WIDTH  high-phase length in ticks
- i_low_ticks  input  WIDTH  low-phase length in ticks
- o_pulse  output  1  generated line (registered)
- o_rise  output  1  one-cycle strobe, coincident with the first high cycle of o_pulse
- o_fall  output  1  one-cycle strobe, coincident with the first low cycle of o_pulse after high
- o_done  output  1  one-cycle strobe on the final clock of a symbol
- o_busy  output  1  state != IDLE

Behaviour:
- Clock/reset: one clock i_clk. Reset i_reset_n is asynchronous, active-low.
- Reset values: o_pulse=0, o_rise=0, o_fall=0, o_done=0, o_busy=0, o_ready=0 during reset, state=IDLE, prescaler=0, tick counter=0.
- Reset mid-symbol: the symbol is aborted immediately. o_pulse drops asynchronously. No o_fall or o_done is generated.
- Transfer occurs when i_valid & o_ready in cycle T. Inputs are sampled only at transfer; later input changes are ignored.
- o_ready is combinational from state/counters. It is 1 when:
  - state is IDLE, or
  - on the final clock of the current symbol (back-to-back, zero gap).
- o_ready is 0 in all other cycles. i_valid held while o_ready=0 is not consumed.
- FSM states: IDLE, HIGH, LOW.
- Transfer with H>0: next state HIGH. Prescaler=0, tick counter=H. o_pulse=1 from T+1.
- Transfer with H=0, L>0: next state LOW. Prescaler=0, tick counter=L. o_pulse stays 0; no strobes.
- Transfer with H=0, L=0: state stays IDLE. o_done=1 at T+1 only. o_pulse unchanged (0).
- Tick mechanics: the prescaler counts 0..DIVISOR-1 and wraps. On wrap, the tick counter decrements. A phase ends on the clock where the prescaler is DIVISOR-1 and the tick counter is 1.
- HIGH end, L>0: go to LOW, load L, prescaler=0. o_pulse=0 on the next clock.
- HIGH end, L=0: this is the symbol's final clock.
- LOW end: this is the symbol's final clock.
- On the final clock of a symbol:
  - o_done=1 on that clock (combinational strobe aligned with o_ready), not registered later.
  - If a transfer occurs on that clock, the new symbol starts at the next clock per the transfer rules above.
  - Otherwise, go to IDLE with o_pulse=0.
- Consecutive high phases: if a symbol ends high (L=0) and the next starts high, o_pulse stays 1 continuously. No o_fall/o_rise is emitted at the join.
- o_rise/o_fall: registered. o_rise=1 exactly in the first cycle o_pulse transitions 0→1; o_fall=1 in the first cycle it transitions 1→0. Both are derived from the next-state of o_pulse.
- Arithmetic: tick counter is WIDTH bits and never underflows, because loads of 0 are never made into a running phase. Prescaler width is max(1, clog2(DIVISOR)).
- DIVISOR=1: prescaler is held at 0; every clock is a tick.

Test Plan:
- DIVISOR=5, H=3, L=2, transfer at T:
  - o_pulse=1 for T+1..T+15, o_rise at T+1.
  - o_pulse=0 for T+16..T+25, o_fall at T+16.
  - o_done=1 and o_ready=1 at T+25; IDLE at T+26.
- Back-to-back: second symbol H=1, L=1 held valid during the first symbol.
  - Accepted at T+25; o_pulse=1 at T+26..T+30, o_rise at T+26.
  - No idle gap between symbols; o_ready=0 throughout T+1..T+24.
- Zero widths:
  - H=0, L=4: o_pulse stays 0 for 20 clocks; o_done at T+20.
  - H=2, L=0 followed immediately by H=2, L=0: o_pulse high 20 contiguous clocks with single o_rise/o_fall.
  - H=0, L=0: o_done only at T+1.
- DIVISOR=1, H=1, L=1: o_pulse high T+1, low T+2; o_done at T+2.
- Reset asserted mid-HIGH at T+7: o_pulse=0 immediately, no strobes. After release: o_ready=1, o_busy=0, and a fresh symbol times correctly from prescaler 0.
- Backpressure/stability: i_valid held high with input values changing while busy. Only the value present on the transfer cycle is transmitted; no extra transfer occurs.
